// File: rtl/system_mdr_pkg.sv
// Shared types and constants for the multiply/divide/root subsystem.
package system_mdr_pkg;

  localparam int DW_DEF      = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef logic [DW_DEF-1:0] data_t;
  typedef logic [2:0]        enb_t;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_ROOT = 2'b10,
    OP_ILL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_NEGROOT = 2'b10,
    ERR_ILL_TMO = 2'b11
  } err_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_LOAD_Y = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam enb_t ENB_NONE = 3'b000;
  localparam enb_t ENB_MULT = 3'b001;
  localparam enb_t ENB_DIV  = 3'b010;
  localparam enb_t ENB_ROOT = 3'b100;

  // Core enable for a legal op; illegal op never enables anything.
  function automatic enb_t op_onehot(input logic [1:0] op);
    enb_t enb;
    case (op)
      OP_MULT: enb = ENB_MULT;
      OP_DIV:  enb = ENB_DIV;
      OP_ROOT: enb = ENB_ROOT;
      default: enb = ENB_NONE;
    endcase
    return enb;
  endfunction

endpackage

// File: rtl/mdr_timeout_counter.sv
// Counts WAIT cycles; o_expire marks the cycle whose increment reaches TIMEOUT.
module mdr_timeout_counter
  import system_mdr_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  // Up-counter, cleared per transaction, saturating at TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_enable && (r_count == C_LAST);

endmodule

// File: rtl/mdr_operand_sequencer.sv
// Operand sequencer for the multiply/divide/root core.
// Optional operand check (div-by-zero, negative root) enabled by MDR_OPERAND_CHECK_EN.
//
//   state  | meaning
//   IDLE   | waiting for i_start
//   LOAD_X | waiting for operand X (illegal op exits to ERROR)
//   LOAD_Y | waiting for operand Y (mult/div only)
//   ISSUE  | operand check, raise core enable
//   WAIT   | enable held, waiting for i_done or timeout
//   DONE   | result valid, holds until next i_start
//   ERROR  | error code valid, holds until next i_start
module mdr_operand_sequencer
  import system_mdr_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_done,
  output logic [DW-1:0] o_dataX,
  output logic [DW-1:0] o_dataY,
  output logic [2:0]    o_enable,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_error,
  output logic [1:0]    o_err_code
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD_X = ST_LOAD_X;
  localparam logic [2:0] S_LOAD_Y = ST_LOAD_Y;
  localparam logic [2:0] S_ISSUE  = ST_ISSUE;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_DONE   = ST_DONE;
  localparam logic [2:0] S_ERROR  = ST_ERROR;

  logic [2:0]    r_state;
  logic [1:0]    r_op;
  logic [DW-1:0] r_data_x;
  logic [DW-1:0] r_data_y;
  logic [2:0]    r_enable;
  logic          r_valid;
  logic          r_error;
  logic [1:0]    r_err_code;

  logic          w_accept_start;
  logic          w_in_wait;
  logic          w_expire;
  logic          w_check_fail;
  logic [1:0]    w_check_code;

  assign w_accept_start = i_start &&
                          ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_in_wait      = (r_state == S_WAIT);

  mdr_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept_start),
    .i_enable (w_in_wait),
    .o_expire (w_expire)
  );

`ifdef MDR_OPERAND_CHECK_EN
  // Operand legality evaluated on the registered operands during ISSUE.
  always_comb begin
    w_check_fail = 1'b0;
    w_check_code = ERR_NONE;
    if ((r_op == OP_DIV) && (r_data_y == '0)) begin
      w_check_fail = 1'b1;
      w_check_code = ERR_DIV0;
    end else if ((r_op == OP_ROOT) && r_data_x[DW-1]) begin
      w_check_fail = 1'b1;
      w_check_code = ERR_NEGROOT;
    end
  end
`else
  assign w_check_fail = 1'b0;
  assign w_check_code = ERR_NONE;
`endif

  // Main sequencing FSM with its registered operand and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op       <= OP_MULT;
      r_data_x   <= '0;
      r_data_y   <= '0;
      r_enable   <= ENB_NONE;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_op       <= i_op;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_state    <= S_LOAD_X;
          end
        end
        S_LOAD_X: begin
          if (r_op == OP_ILL) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_ILL_TMO;
            r_state    <= S_ERROR;
          end else if (i_load) begin
            r_data_x <= i_data;
            if (r_op == OP_ROOT) begin
              r_data_y <= '0;
              r_state  <= S_ISSUE;
            end else begin
              r_state  <= S_LOAD_Y;
            end
          end
        end
        S_LOAD_Y: begin
          if (i_load) begin
            r_data_y <= i_data;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_check_fail) begin
            r_error    <= 1'b1;
            r_err_code <= w_check_code;
            r_state    <= S_ERROR;
          end else begin
            r_enable <= op_onehot(r_op);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Done on the expiring cycle still counts as a completion.
          if (i_done) begin
            r_enable <= ENB_NONE;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_expire) begin
            r_enable   <= ENB_NONE;
            r_error    <= 1'b1;
            r_err_code <= ERR_ILL_TMO;
            r_state    <= S_ERROR;
          end
        end
        default: begin
          r_enable <= ENB_NONE;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dataX    = r_data_x;
  assign o_dataY    = r_data_y;
  assign o_enable   = r_enable;
  assign o_busy     = (r_state == S_LOAD_X) || (r_state == S_LOAD_Y) ||
                      (r_state == S_ISSUE)  || (r_state == S_WAIT);
  assign o_valid    = r_valid;
  assign o_error    = r_error;
  assign o_err_code = r_err_code;

endmodule
